// File: rtl/scroll_frame_renderer_pkg.sv
// Shared types, default colours and the span-compare helper for the frame renderer.
// The comparisons use a signed 64-bit domain, so negative screen offsets never wrap.
package render_pkg;

    localparam logic [23:0] DEF_BKCOLOR     = 24'h0faf0f;
    localparam logic [23:0] DEF_DOODLE_COLOR = 24'h00ff00;
    localparam logic [23:0] DEF_BLOCK_COLOR  = 24'hff0000;

    localparam int SPAN_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SCAN,
        DRAIN
    } state_t;

    // True when origin <= p < origin+len.
    function automatic logic in_span(input logic signed [SPAN_W-1:0] p,
                                     input logic signed [SPAN_W-1:0] origin,
                                     input logic [31:0]              len);
        logic signed [SPAN_W-1:0] lim;
        lim = origin + $signed({{(SPAN_W-32){1'b0}}, len});
        return (p >= origin) && (p < lim);
    endfunction

endpackage

// File: rtl/scroll_frame_renderer_if.sv
// Pixel stream from the renderer to the display/framebuffer writer.
// The stream uses valid/ready flow control and carries per-pixel position and frame flags.
interface scroll_frame_renderer_if #(
    parameter int XW = 9,
    parameter int YW = 10
);
    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [23:0]   pix_color;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/scroll_frame_renderer_raster_counter.sv
// Raster x/y counter. It advances x first and then y, and wraps to (0,0) after the last pixel.
module raster_counter
    import render_pkg::*;
#(
    parameter int W  = 400,
    parameter int H  = 700,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          eof,
    output logic          last
);

    localparam logic [XW-1:0] XMAX = XW'(W - 1);
    localparam logic [YW-1:0] YMAX = YW'(H - 1);

    assign sof  = (x == '0) && (y == '0);
    assign eol  = (x == XMAX);
    assign eof  = eol && (y == YMAX);
    assign last = eof;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (eol) begin
                x <= '0;
                y <= eof ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/scroll_frame_renderer.sv
// Whole-frame renderer. It snapshots the scene on start, raster-scans the screen and
// streams one colour per pixel through a 2-stage hit/colour pipeline with backpressure.
module scroll_frame_renderer
    import render_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = 400,
    parameter int          SCREEN_HEIGHT = 700,
    parameter int          BLOCK_WIDTH   = 40,
    parameter int          BLOCK_HEIGHT  = 5,
    parameter int          DOODLE_SIZE   = 8,
    parameter int          N_BLOCKS      = 16,
    parameter int          COORD_W       = 32,
    parameter logic [23:0] BKCOLOR       = DEF_BKCOLOR,
    parameter logic [23:0] DOODLE_COLOR  = DEF_DOODLE_COLOR,
    parameter logic [23:0] BLOCK_COLOR   = DEF_BLOCK_COLOR
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [COORD_W-1:0]          doodle_x,
    input  logic [COORD_W-1:0]          doodle_y,
    input  logic [COORD_W-1:0]          min_y,
    input  logic [N_BLOCKS*COORD_W-1:0] blocks_x,
    input  logic [N_BLOCKS*COORD_W-1:0] blocks_y,
    input  logic [N_BLOCKS-1:0]         block_active,
    output logic                        busy,
    output logic                        done,
    scroll_frame_renderer_if.master     pix
);

    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam int CW = COORD_W;

    state_t                state;
    logic [CW-1:0]         sh_dx, sh_dy, sh_miny;
    logic [N_BLOCKS*CW-1:0] sh_bx, sh_by;
    logic [N_BLOCKS-1:0]   sh_act;

    logic                  stall, adv;
    logic [XW-1:0]         cx;
    logic [YW-1:0]         cy;
    logic                  c_sof, c_eol, c_eof, c_last;

    logic signed [SPAN_W-1:0] px_s, py_s, dx_s, dy_s;
    logic [N_BLOCKS-1:0]   hit_c;
    logic                  dhit_c;

    logic                  vld_p1, dhit_p1, sof_p1, eol_p1, eof_p1;
    logic [N_BLOCKS-1:0]   hit_p1;
    logic [XW-1:0]         x_p1;
    logic [YW-1:0]         y_p1;

    logic                  vld_p2, sof_p2, eol_p2, eof_p2;
    logic [23:0]           col_p2;
    logic [XW-1:0]         x_p2;
    logic [YW-1:0]         y_p2;

    // World Y to screen Y in a widened signed domain; objects above the view go negative.
    function automatic logic signed [SPAN_W-1:0] scr_y(input logic [CW-1:0] wy,
                                                       input logic [CW-1:0] miny);
        logic signed [CW:0] d;
        d = $signed({1'b0, wy}) - $signed({1'b0, miny});
        return {{(SPAN_W-CW-1){d[CW]}}, d};
    endfunction

    function automatic logic [23:0] pick_color(input logic dhit, input logic bhit);
        if (dhit)      return DOODLE_COLOR;
        else if (bhit) return BLOCK_COLOR;
        else           return BKCOLOR;
    endfunction

    assign stall = vld_p2 & ~pix.pix_ready;
    assign adv   = (state == SCAN) & ~stall;

    raster_counter #(
        .W  (SCREEN_WIDTH),
        .H  (SCREEN_HEIGHT),
        .XW (XW),
        .YW (YW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == LATCH),
        .en    (adv),
        .x     (cx),
        .y     (cy),
        .sof   (c_sof),
        .eol   (c_eol),
        .eof   (c_eof),
        .last  (c_last)
    );

    assign px_s = {{(SPAN_W-XW){1'b0}}, cx};
    assign py_s = {{(SPAN_W-YW){1'b0}}, cy};
    assign dx_s = {{(SPAN_W-CW){1'b0}}, sh_dx};
    assign dy_s = scr_y(sh_dy, sh_miny);

    assign dhit_c = in_span(px_s, dx_s, 32'(DOODLE_SIZE)) &
                    in_span(py_s, dy_s, 32'(DOODLE_SIZE));

    for (genvar i = 0; i < N_BLOCKS; i++) begin : g_hit
        logic signed [SPAN_W-1:0] bx_s, by_s;
        assign bx_s     = {{(SPAN_W-CW){1'b0}}, sh_bx[i*CW +: CW]};
        assign by_s     = scr_y(sh_by[i*CW +: CW], sh_miny);
        assign hit_c[i] = sh_act[i] &
                          in_span(px_s, bx_s, 32'(BLOCK_WIDTH)) &
                          in_span(py_s, by_s, 32'(BLOCK_HEIGHT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sh_dx   <= '0;
            sh_dy   <= '0;
            sh_miny <= '0;
            sh_bx   <= '0;
            sh_by   <= '0;
            sh_act  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    sh_dx   <= doodle_x;
                    sh_dy   <= doodle_y;
                    sh_miny <= min_y;
                    sh_bx   <= blocks_x;
                    sh_by   <= blocks_y;
                    sh_act  <= block_active;
                    state   <= SCAN;
                end
                SCAN: begin
                    if (adv && c_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (vld_p2 && pix.pix_ready && eof_p2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            hit_p1  <= '0;
            dhit_p1 <= 1'b0;
            x_p1    <= '0;
            y_p1    <= '0;
            sof_p1  <= 1'b0;
            eol_p1  <= 1'b0;
            eof_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            col_p2  <= BKCOLOR;
            x_p2    <= '0;
            y_p2    <= '0;
            sof_p2  <= 1'b0;
            eol_p2  <= 1'b0;
            eof_p2  <= 1'b0;
        end else if (!stall) begin
            // Stage 1: per-slot and doodle hits for the counter pixel
            vld_p1  <= adv;
            hit_p1  <= hit_c;
            dhit_p1 <= dhit_c;
            x_p1    <= cx;
            y_p1    <= cy;
            sof_p1  <= c_sof;
            eol_p1  <= c_eol;
            eof_p1  <= c_eof;
            // Stage 2: priority colour plus position and flags
            vld_p2  <= vld_p1;
            col_p2  <= pick_color(dhit_p1, |hit_p1);
            x_p2    <= x_p1;
            y_p2    <= y_p1;
            sof_p2  <= sof_p1;
            eol_p2  <= eol_p1;
            eof_p2  <= eof_p1;
        end
    end

    assign pix.pix_valid = vld_p2;
    assign pix.pix_color = col_p2;
    assign pix.pix_x     = x_p2;
    assign pix.pix_y     = y_p2;
    assign pix.pix_sof   = sof_p2;
    assign pix.pix_eol   = eol_p2;
    assign pix.pix_eof   = eof_p2;

endmodule

// File: tb/tb_scroll_frame_renderer.sv
// Directed bench for scroll_frame_renderer on an 8x4 screen with 3x1 blocks and a 2x2 doodle.
module tb_scroll_frame_renderer;

    localparam int W = 8, H = 4, NB = 4, CW = 32;
    localparam logic [23:0] BK = 24'h0faf0f;
    localparam logic [23:0] DC = 24'h00ff00;
    localparam logic [23:0] BC = 24'hff0000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     doodle_x, doodle_y, min_y;
    logic [NB*CW-1:0]  blocks_x, blocks_y;
    logic [NB-1:0]     block_active;
    logic              busy, done;

    scroll_frame_renderer_if #(.XW(3), .YW(2)) pif();

    scroll_frame_renderer #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .BLOCK_WIDTH(3), .BLOCK_HEIGHT(1),
        .DOODLE_SIZE(2), .N_BLOCKS(NB), .COORD_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .doodle_x(doodle_x), .doodle_y(doodle_y), .min_y(min_y),
        .blocks_x(blocks_x), .blocks_y(blocks_y), .block_active(block_active),
        .busy(busy), .done(done), .pix(pif)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    logic [2:0]  cap_x [32];
    logic [1:0]  cap_y [32];
    logic [23:0] cap_c [32];
    logic [2:0]  cap_f [32];
    int          npix, ndone, first_vld, eof_cyc, done_cyc, stall_bad;
    logic        busy0;

    task automatic set_scene(input int dx, input int dy, input int my);
        doodle_x     = CW'(dx);
        doodle_y     = CW'(dy);
        min_y        = CW'(my);
        blocks_x     = '0;
        blocks_y     = '0;
        block_active = '0;
    endtask

    task automatic set_block(input int i, input int bx, input int by, input bit act);
        blocks_x[i*CW +: CW] = CW'(bx);
        blocks_y[i*CW +: CW] = CW'(by);
        block_active[i]      = act;
    endtask

    // Requests a frame and records accepted pixels; ready follows 1-0-0-1 when bp is set.
    task automatic run_frame(input bit bp, input int again_at, input int stop_at);
        int          cyc;
        int          tail;
        bit          again_sent;
        bit          hold;
        logic [2:0]  hx;
        logic [1:0]  hy;
        logic [23:0] hc;
        logic [2:0]  hf;
        logic [3:0]  pat;
        pat = 4'b1001;
        npix = 0; ndone = 0; first_vld = -1; eof_cyc = -1; done_cyc = -1; stall_bad = 0;
        again_sent = 0; hold = 0; hx = '0; hy = '0; hc = '0; hf = '0;
        @(negedge clk);
        start = 1'b1;
        pif.pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        cyc = 0;
        tail = 0;
        while (cyc < 1000 && tail < 4) begin
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (pif.pix_valid && first_vld < 0) first_vld = cyc;
            if (hold) begin
                if (!pif.pix_valid || pif.pix_x !== hx || pif.pix_y !== hy || pif.pix_color !== hc ||
                    {pif.pix_sof, pif.pix_eol, pif.pix_eof} !== hf)
                    stall_bad++;
            end
            hold = 0;
            pif.pix_ready = bp ? pat[cyc[1:0]] : 1'b1;
            if (again_at >= 0 && !again_sent && npix >= again_at) begin
                start = 1'b1;
                again_sent = 1;
            end else begin
                start = 1'b0;
            end
            if (pif.pix_valid) begin
                if (pif.pix_ready) begin
                    if (npix < 32) begin
                        cap_x[npix] = pif.pix_x;
                        cap_y[npix] = pif.pix_y;
                        cap_c[npix] = pif.pix_color;
                        cap_f[npix] = {pif.pix_sof, pif.pix_eol, pif.pix_eof};
                    end
                    if (pif.pix_eof) eof_cyc = cyc;
                    npix++;
                end else begin
                    hold = 1;
                    hx = pif.pix_x; hy = pif.pix_y; hc = pif.pix_color;
                    hf = {pif.pix_sof, pif.pix_eol, pif.pix_eof};
                end
            end
            if (stop_at < 32 && npix >= stop_at) break;
            if (npix >= stop_at) tail++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        pif.pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || pif.pix_valid !== 1'b0) begin
            nmis++;
            $display("FAIL reset_ctrl got busy=%b done=%b valid=%b want 0 0 0", busy, done, pif.pix_valid);
        end
        nvec++;
        if ({pif.pix_sof, pif.pix_eol, pif.pix_eof} !== 3'b000) begin
            nmis++;
            $display("FAIL reset_flags got %b want 000", {pif.pix_sof, pif.pix_eol, pif.pix_eof});
        end
        nvec++;
        if (pif.pix_x !== 3'd0 || pif.pix_y !== 2'd0) begin
            nmis++;
            $display("FAIL reset_xy got (%0d,%0d) want (0,0)", pif.pix_x, pif.pix_y);
        end
        nvec++;
        if (pif.pix_color !== BK) begin
            nmis++;
            $display("FAIL reset_color got %h want %h", pif.pix_color, BK);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_background();
        logic [7:0] got, exp;
        set_scene(100, 100, 0);
        set_block(0, 0, 0, 0);
        set_block(1, 2, 1, 0);
        run_frame(0, -1, 32);
        nvec++;
        if (npix != 32) begin
            nmis++;
            $display("FAIL bg_count got %0d want 32", npix);
        end
        for (int i = 0; i < 32; i++) begin
            got = {cap_x[i], cap_y[i], cap_f[i]};
            exp = {3'(i % 8), 2'(i / 8), (i == 0), (i % 8 == 7), (i == 31)};
            nvec++;
            if (got !== exp) begin
                nmis++;
                $display("FAIL bg_pos[%0d] got x=%0d y=%0d f=%b want x=%0d y=%0d f=%b",
                         i, cap_x[i], cap_y[i], cap_f[i], i % 8, i / 8, exp[2:0]);
            end
            nvec++;
            if (cap_c[i] !== BK) begin
                nmis++;
                $display("FAIL bg_color[%0d] got %h want %h", i, cap_c[i], BK);
            end
        end
        nvec++;
        if (first_vld != 3 || busy0 !== 1'b1) begin
            nmis++;
            $display("FAIL bg_latency got first_valid=%0d busy=%b want 3 1", first_vld, busy0);
        end
        nvec++;
        if (ndone != 1 || done_cyc != eof_cyc + 1) begin
            nmis++;
            $display("FAIL bg_done got pulses=%0d at=%0d want 1 at %0d", ndone, done_cyc, eof_cyc + 1);
        end
        nvec++;
        if (busy !== 1'b0) begin
            nmis++;
            $display("FAIL bg_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_block();
        logic [23:0] exp;
        int x, y;
        set_scene(100, 100, 4);
        set_block(0, 2, 5, 1);
        set_block(1, 0, 4, 0);
        set_block(2, 5, 6, 0);
        run_frame(0, -1, 32);
        nvec++;
        if (npix != 32) begin
            nmis++;
            $display("FAIL blk_count got %0d want 32", npix);
        end
        for (int i = 0; i < 32; i++) begin
            x = i % 8; y = i / 8;
            exp = (y == 1 && x >= 2 && x <= 4) ? BC : BK;
            nvec++;
            if (cap_c[i] !== exp) begin
                nmis++;
                $display("FAIL blk_color(%0d,%0d) got %h want %h", x, y, cap_c[i], exp);
            end
        end
    endtask

    task automatic overlap_scene();
        set_scene(3, 1, 0);
        set_block(0, 2, 1, 1);
        set_block(1, 0, 0, 0);
        set_block(2, 4, 3, 1);
        set_block(3, 6, 3, 1);
    endtask

    task automatic test_overlap();
        logic [23:0] exp;
        int x, y;
        overlap_scene();
        run_frame(0, -1, 32);
        nvec++;
        if (npix != 32) begin
            nmis++;
            $display("FAIL ovl_count got %0d want 32", npix);
        end
        for (int i = 0; i < 32; i++) begin
            x = i % 8; y = i / 8;
            if (x >= 3 && x <= 4 && y >= 1 && y <= 2)            exp = DC;
            else if ((y == 1 && x >= 2 && x <= 4) || (y == 3 && x >= 4)) exp = BC;
            else                                                  exp = BK;
            nvec++;
            if (cap_c[i] !== exp) begin
                nmis++;
                $display("FAIL ovl_color(%0d,%0d) got %h want %h", x, y, cap_c[i], exp);
            end
        end
    endtask

    task automatic test_clip_top();
        logic [23:0] exp;
        int x, y;
        set_scene(3, 3, 4);
        set_block(0, 0, 2, 1);
        run_frame(0, -1, 32);
        nvec++;
        if (npix != 32) begin
            nmis++;
            $display("FAIL clip_count got %0d want 32", npix);
        end
        for (int i = 0; i < 32; i++) begin
            x = i % 8; y = i / 8;
            exp = (y == 0 && x >= 3 && x <= 4) ? DC : BK;
            nvec++;
            if (cap_c[i] !== exp) begin
                nmis++;
                $display("FAIL clip_color(%0d,%0d) got %h want %h", x, y, cap_c[i], exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] exp;
        int x, y;
        overlap_scene();
        run_frame(1, 12, 32);
        nvec++;
        if (npix != 32) begin
            nmis++;
            $display("FAIL bp_count got %0d want 32", npix);
        end
        nvec++;
        if (stall_bad != 0) begin
            nmis++;
            $display("FAIL bp_stable got %0d unstable stall cycles want 0", stall_bad);
        end
        nvec++;
        if (ndone != 1) begin
            nmis++;
            $display("FAIL bp_done got %0d pulses want 1", ndone);
        end
        for (int i = 0; i < 32; i++) begin
            x = i % 8; y = i / 8;
            if (x >= 3 && x <= 4 && y >= 1 && y <= 2)            exp = DC;
            else if ((y == 1 && x >= 2 && x <= 4) || (y == 3 && x >= 4)) exp = BC;
            else                                                  exp = BK;
            nvec++;
            if (cap_x[i] !== 3'(x) || cap_y[i] !== 2'(y) || cap_c[i] !== exp) begin
                nmis++;
                $display("FAIL bp_pix[%0d] got (%0d,%0d) %h want (%0d,%0d) %h",
                         i, cap_x[i], cap_y[i], cap_c[i], x, y, exp);
            end
        end
    endtask

    task automatic test_restart_reset();
        logic [23:0] exp;
        int x, y;
        int bad;
        set_scene(100, 100, 4);
        set_block(0, 2, 5, 1);
        run_frame(0, 4, 10);
        nvec++;
        if (npix != 10) begin
            nmis++;
            $display("FAIL rst_partial got %0d pixels want 10", npix);
        end
        for (int i = 0; i < 10; i++) begin
            nvec++;
            if (cap_x[i] !== 3'(i % 8) || cap_y[i] !== 2'(i / 8)) begin
                nmis++;
                $display("FAIL rst_order[%0d] got (%0d,%0d) want (%0d,%0d)",
                         i, cap_x[i], cap_y[i], i % 8, i / 8);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || pif.pix_valid !== 1'b0 ||
            {pif.pix_sof, pif.pix_eol, pif.pix_eof} !== 3'b000 ||
            pif.pix_x !== 3'd0 || pif.pix_y !== 2'd0 || pif.pix_color !== BK) begin
            nmis++;
            $display("FAIL rst_abort got busy=%b done=%b valid=%b x=%0d y=%0d c=%h want 0 0 0 0 0 %h",
                     busy, done, pif.pix_valid, pif.pix_x, pif.pix_y, pif.pix_color, BK);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || pif.pix_valid !== 1'b0) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nmis++;
            $display("FAIL rst_quiet got %0d active cycles after reset want 0", bad);
        end
        run_frame(0, -1, 32);
        nvec++;
        if (npix != 32 || ndone != 1) begin
            nmis++;
            $display("FAIL rst_reframe got pixels=%0d done=%0d want 32 1", npix, ndone);
        end
        for (int i = 0; i < 32; i++) begin
            x = i % 8; y = i / 8;
            exp = (y == 1 && x >= 2 && x <= 4) ? BC : BK;
            nvec++;
            if (cap_x[i] !== 3'(x) || cap_y[i] !== 2'(y) || cap_c[i] !== exp) begin
                nmis++;
                $display("FAIL rst_pix[%0d] got (%0d,%0d) %h want (%0d,%0d) %h",
                         i, cap_x[i], cap_y[i], cap_c[i], x, y, exp);
            end
        end
    endtask

    initial begin
        pif.pix_ready = 1'b1;
        set_scene(0, 0, 0);
        test_reset();
        test_background();
        test_block();
        test_overlap();
        test_clip_top();
        test_backpressure();
        test_restart_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
